clairisc_rf2r1w: RTL and testbench
==================================

Name: clairisc_rf2r1w

Overview:
Parametrised data-memory register file for the clairisc core. It replaces the single-port 8x128 simulation register file. It provides two registered read ports, one registered write port and per-port write-to-read forwarding. A built-in init sequencer sweeps every entry to a known value after reset or on request. It sits between the decode/operand-fetch stage (read ports A/B) and the writeback stage (write port).

Parameters:
DATA_W, 8, word width in bits (full width on every path, including the forwarding register)
ADDR_W, 7, address width
DEPTH, 128, number of implemented entries; must satisfy 1 <= DEPTH <= 2**ADDR_W
INIT_VAL, 0, value written to every entry by the init sweep

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
clr  in  1  synchronous request to re-run the init sweep
wr_en  in  1  write enable
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_addr_a  in  ADDR_W  read address, port A
rd_addr_b  in  ADDR_W  read address, port B
rd_data_a  out  DATA_W  read data, port A
rd_data_b  out  DATA_W  read data, port B
ready  out  1  1 = array initialised; accepts writes and returns valid reads

Behaviour:
- Reset (async, rst=1):
  - state=INIT, sweep counter=0, ready=0.
  - All input pipeline registers clear: r_we=0, all addresses and data 0.
  - rd_data_a/b read 0.
  - Array contents are not reset by rst; the sweep initialises them.
- Input stage:
  - Every edge registers rd_addr_a, rd_addr_b, wr_en, wr_addr and wr_data into r_* registers.
  - Write commit: mem[r_wr_addr] <= r_wr_data on the next edge when r_we=1 and state=RUN.
  - Write-to-storage latency is 2 edges.
- Read path:
  - rd_data_x is combinational from r_rd_addr_x.
  - Latency: data appears 1 edge after the address is presented.
- Forwarding, per port independently:
  - If r_we=1 and r_rd_addr_x==r_wr_addr, rd_data_x=r_wr_data; otherwise rd_data_x=mem[r_rd_addr_x].
  - Both ports may forward in the same cycle.
- Out-of-range addresses (>= DEPTH):
  - Writes are dropped.
  - Reads return 0.
  - No forwarding from a dropped write.
- State machine (INIT, RUN):
  - INIT: each edge writes INIT_VAL to mem[cnt] and increments cnt. When cnt==DEPTH-1 is written, go to RUN.
  - In INIT: ready=0, rd_data_a/b=0, wr_en ignored, r_we forced to 0.
  - ready rises exactly DEPTH edges after rst deasserts.
  - RUN: ready=1; normal operation.
  - clr=1 sampled in RUN: next state INIT, cnt=0, ready=0 from that edge.
  - A write captured in r_* on the clr edge is dropped.
  - clr during INIT restarts the sweep at cnt=0.
  - rst asserted mid-sweep or mid-write returns immediately to the reset state; the sweep restarts on deassertion.
- Counter width: clog2(DEPTH) + 1 bits; no wrap-around beyond DEPTH-1.
- Simultaneous events:
  - clr has priority over wr_en.
  - Read and write to the same address in the same input cycle: the read returns the new data via forwarding.

Decomposition:
- clairisc_def.h holds:
  - state encodings RF_INIT=1'b0, RF_RUN=1'b1;
  - default RF_DATA_W, RF_ADDR_W, RF_DEPTH.
- Sub-module rf_init_seq: the INIT/RUN FSM plus sweep counter.
  - Inputs: clk, rst, clr.
  - Outputs: init_we, init_addr, ready.
- The top level muxes init_we/init_addr/INIT_VAL onto the array write port during INIT.

Test Plan:
- Reset sweep: rst high 3 cycles then low; hold rd_addr_a=127 -> ready=0 for 128 edges, 1 after; rd_data_a=0x00 once ready.
- Basic write/read: write 0xA5 to addr 5; 2 cycles later set rd_addr_a=5 -> rd_data_a=0xA5 one edge later; port B on addr 6 reads 0x00.
- Forwarding: same cycle wr_en=1, wr_addr=9, wr_data=0x3C, rd_addr_a=rd_addr_b=9 -> both ports show 0x3C one edge later, and 0x3C persists from storage on later reads.
- Out of range (DEPTH=100): write 0xFF to addr 110 -> rd_data_a=0x00 for addr 110 (including the forwarding cycle); addr 99 writable and readable.
- clr mid-run: fill addr 0–3 with 0x11; pulse clr alongside a write of 0x77 to addr 2 -> ready drops, write is dropped, after 128 edges all of addr 0–3 read 0x00.
- rst mid-sweep: assert rst at sweep cycle 40 -> ready stays 0; after release, ready rises exactly 128 edges later.

Source files
------------

// File: rtl/clairisc_rf2r1w_pkg.sv
// rtl/clairisc_rf2r1w_pkg.sv - shared types and defaults for the clairisc register file
package clairisc_rf2r1w_pkg;

   localparam int RF_DATA_W = 8;
   localparam int RF_ADDR_W = 7;
   localparam int RF_DEPTH  = 128;

   typedef enum logic {
      RF_INIT = 1'b0,
      RF_RUN  = 1'b1
   } rf_state_e;

   // Sweep counter width: index range plus one bit of headroom
   function automatic int rf_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/clairisc_rf2r1w_if.sv
// rtl/clairisc_rf2r1w_if.sv - register file access bus (read ports A/B, write port, control)
interface clairisc_rf2r1w_if
   import clairisc_rf2r1w_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W
) ();

   logic              clr;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [DATA_W-1:0] rd_data_a;
   logic [DATA_W-1:0] rd_data_b;
   logic              ready;

   modport master (
      output clr, wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
      input  rd_data_a, rd_data_b, ready
   );

   modport slave (
      input  clr, wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
      output rd_data_a, rd_data_b, ready
   );

endinterface

// File: rtl/clairisc_rf2r1w_init_seq.sv
// rtl/clairisc_rf2r1w_init_seq.sv - INIT/RUN sequencer that sweeps every array entry
module clairisc_rf2r1w_init_seq
   import clairisc_rf2r1w_pkg::*;
#(
   parameter int ADDR_W = RF_ADDR_W,
   parameter int DEPTH  = RF_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   output logic              init_we,
   output logic [ADDR_W-1:0] init_addr,
   output logic              ready
);

   localparam int               CNT_W = rf_cnt_w(DEPTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEPTH - 1);

   rf_state_e        state;
   logic [CNT_W-1:0] cnt;

   // State, sweep counter and ready flag; clr restarts the sweep from any state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RF_INIT;
         cnt   <= '0;
         ready <= 1'b0;
      end else if (clr) begin
         state <= RF_INIT;
         cnt   <= '0;
         ready <= 1'b0;
      end else begin
         case (state)
            RF_INIT: begin
               if (cnt == LAST) begin
                  state <= RF_RUN;
                  cnt   <= '0;
                  ready <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RF_RUN: begin
               state <= RF_RUN;
            end
         endcase
      end
   end

   assign init_we   = (state == RF_INIT);
   assign init_addr = ADDR_W'(cnt);

endmodule

// File: rtl/clairisc_rf2r1w.sv
// rtl/clairisc_rf2r1w.sv - two-read one-write register file with forwarding and init sweep
module clairisc_rf2r1w
   import clairisc_rf2r1w_pkg::*;
#(
   parameter int                DATA_W   = RF_DATA_W,
   parameter int                ADDR_W   = RF_ADDR_W,
   parameter int                DEPTH    = RF_DEPTH,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic            clk,
   input  logic            rst,
   clairisc_rf2r1w_if.slave rf
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   // Addresses at or above DEPTH have no storage behind them
   function automatic logic in_range(input logic [ADDR_W-1:0] addr);
      return {1'b0, addr} < DEPTH_L;
   endfunction

   logic              init_we;
   logic [ADDR_W-1:0] init_addr;
   logic              ready;

   logic              r_we;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [DATA_W-1:0] r_wr_data;
   logic [ADDR_W-1:0] r_rd_addr_a;
   logic [ADDR_W-1:0] r_rd_addr_b;
   logic              commit;

   logic [DATA_W-1:0] mem [DEPTH];

   clairisc_rf2r1w_init_seq #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_init_seq (
      .clk       (clk),
      .rst       (rst),
      .clr       (rf.clr),
      .init_we   (init_we),
      .init_addr (init_addr),
      .ready     (ready)
   );

   // Input pipeline; a write is only accepted while running and not being cleared
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we        <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_rd_addr_a <= '0;
         r_rd_addr_b <= '0;
      end else begin
         r_we        <= rf.wr_en & ready & ~rf.clr;
         r_wr_addr   <= rf.wr_addr;
         r_wr_data   <= rf.wr_data;
         r_rd_addr_a <= rf.rd_addr_a;
         r_rd_addr_b <= rf.rd_addr_b;
      end
   end

   assign commit = r_we & ready & in_range(r_wr_addr);

   // Array write port: the sweep owns it during INIT, the pipelined write otherwise
   always_ff @(posedge clk) begin
      if (init_we) begin
         mem[init_addr] <= INIT_VAL;
      end else if (commit) begin
         mem[r_wr_addr] <= r_wr_data;
      end
   end

   // Port A read with forwarding from the write still in flight
   always_comb begin
      rf.rd_data_a = '0;
      if (ready && in_range(r_rd_addr_a)) begin
         if (r_we && (r_rd_addr_a == r_wr_addr)) begin
            rf.rd_data_a = r_wr_data;
         end else begin
            rf.rd_data_a = mem[r_rd_addr_a];
         end
      end
   end

   // Port B read with forwarding from the write still in flight
   always_comb begin
      rf.rd_data_b = '0;
      if (ready && in_range(r_rd_addr_b)) begin
         if (r_we && (r_rd_addr_b == r_wr_addr)) begin
            rf.rd_data_b = r_wr_data;
         end else begin
            rf.rd_data_b = mem[r_rd_addr_b];
         end
      end
   end

   assign rf.ready = ready;

endmodule

// File: tb/tb_clairisc_rf2r1w.sv
// tb/tb_clairisc_rf2r1w.sv - self-checking bench for clairisc_rf2r1w
module tb_clairisc_rf2r1w;
   import clairisc_rf2r1w_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   clairisc_rf2r1w_if #(.DATA_W(8), .ADDR_W(7)) bus   ();
   clairisc_rf2r1w_if #(.DATA_W(8), .ADDR_W(7)) bus_s ();

   clairisc_rf2r1w #(
      .DATA_W(8), .ADDR_W(7), .DEPTH(128), .INIT_VAL(8'h00)
   ) dut (
      .clk (clk),
      .rst (rst),
      .rf  (bus.slave)
   );

   clairisc_rf2r1w #(
      .DATA_W(8), .ADDR_W(7), .DEPTH(100), .INIT_VAL(8'h5A)
   ) dut_s (
      .clk (clk),
      .rst (rst),
      .rf  (bus_s.slave)
   );

   typedef struct {
      logic       we;
      logic [6:0] wa;
      logic [7:0] wd;
      logic [6:0] ra;
      logic [6:0] rb;
      logic [7:0] ea;
      logic [7:0] eb;
   } vec_t;

   typedef struct {
      int         due;
      int         dev;
      logic [7:0] ea;
      logic [7:0] eb;
      string      name;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[9];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp_v);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   task automatic step();
      exp_t e;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         if (e.dev == 0) begin
            chk8({e.name, "_a"}, bus.rd_data_a, e.ea);
            chk8({e.name, "_b"}, bus.rd_data_b, e.eb);
         end else begin
            chk8({e.name, "_a"}, bus_s.rd_data_a, e.ea);
            chk8({e.name, "_b"}, bus_s.rd_data_b, e.eb);
         end
      end
   endtask

   task automatic drive(input int dev, input logic we, input logic [6:0] wa, input logic [7:0] wd,
                        input logic [6:0] ra, input logic [6:0] rb, input logic c);
      if (dev == 0) begin
         bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
         bus.rd_addr_a = ra; bus.rd_addr_b = rb; bus.clr = c;
      end else begin
         bus_s.wr_en = we; bus_s.wr_addr = wa; bus_s.wr_data = wd;
         bus_s.rd_addr_a = ra; bus_s.rd_addr_b = rb; bus_s.clr = c;
      end
   endtask

   task automatic expect_rd(input int dev, input logic [7:0] ea, input logic [7:0] eb, input string name);
      exp_t e;
      e.due  = cyc + 1;
      e.dev  = dev;
      e.ea   = ea;
      e.eb   = eb;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic wait_ready(input int dev, input int exp_edges, input string name);
      int   n;
      logic r;
      n = 0;
      r = 1'b0;
      while (n < 400 && !r) begin
         step();
         n++;
         r = (dev == 0) ? bus.ready : bus_s.ready;
      end
      chk_int(name, n, exp_edges);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish within bound");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{1'b1, 7'd5,   8'hA5, 7'd0,   7'd6,   8'h00, 8'h00};
      vecs[1] = '{1'b1, 7'd9,   8'h3C, 7'd9,   7'd9,   8'h3C, 8'h3C};
      vecs[2] = '{1'b0, 7'd0,   8'h00, 7'd5,   7'd6,   8'hA5, 8'h00};
      vecs[3] = '{1'b1, 7'd127, 8'h42, 7'd9,   7'd127, 8'h3C, 8'h42};
      vecs[4] = '{1'b1, 7'd9,   8'h99, 7'd9,   7'd127, 8'h99, 8'h42};
      vecs[5] = '{1'b0, 7'd0,   8'h00, 7'd9,   7'd5,   8'h99, 8'hA5};
      vecs[6] = '{1'b1, 7'd0,   8'h01, 7'd0,   7'd1,   8'h01, 8'h00};
      vecs[7] = '{1'b1, 7'd1,   8'h02, 7'd0,   7'd1,   8'h01, 8'h02};
      vecs[8] = '{1'b0, 7'd0,   8'h00, 7'd1,   7'd0,   8'h02, 8'h01};

      drive(0, 1'b0, 7'd0, 8'h00, 7'd127, 7'd0, 1'b0);
      drive(1, 1'b0, 7'd0, 8'h00, 7'd0,   7'd0, 1'b0);

      // Reset and initial sweep
      repeat (3) step();
      chk8("rst_ready", {7'b0, bus.ready}, 8'h00);
      chk8("rst_rd_a", bus.rd_data_a, 8'h00);
      chk8("rst_rd_b", bus.rd_data_b, 8'h00);
      rst = 1'b0;
      wait_ready(0, 128, "sweep_edges");
      chk8("sweep_rd127", bus.rd_data_a, 8'h00);
      chk8("small_ready", {7'b0, bus_s.ready}, 8'h01);

      // Table-driven write/read/forwarding vectors
      for (int i = 0; i < 9; i++) begin
         drive(0, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb, 1'b0);
         expect_rd(0, vecs[i].ea, vecs[i].eb, $sformatf("vec%0d", i));
         step();
      end
      drive(0, 1'b0, 7'd0, 8'h00, 7'd0, 7'd0, 1'b0);

      // Out-of-range handling on the 100-entry instance
      drive(1, 1'b1, 7'd110, 8'hFF, 7'd110, 7'd10, 1'b0);
      expect_rd(1, 8'h00, 8'h5A, "oor_fwd");
      step();
      drive(1, 1'b0, 7'd0, 8'h00, 7'd110, 7'd10, 1'b0);
      expect_rd(1, 8'h00, 8'h5A, "oor_read");
      step();
      drive(1, 1'b1, 7'd99, 8'h66, 7'd99, 7'd50, 1'b0);
      expect_rd(1, 8'h66, 8'h5A, "s99_fwd");
      step();
      drive(1, 1'b0, 7'd0, 8'h00, 7'd98, 7'd99, 1'b0);
      expect_rd(1, 8'h5A, 8'h66, "s99_mem");
      step();

      // clr mid-run with a concurrent write
      for (int a = 0; a < 4; a++) begin
         drive(0, 1'b1, 7'(a), 8'h11, 7'(a), 7'(a), 1'b0);
         expect_rd(0, 8'h11, 8'h11, $sformatf("fill%0d", a));
         step();
      end
      drive(0, 1'b0, 7'd0, 8'h00, 7'd0, 7'd3, 1'b0);
      expect_rd(0, 8'h11, 8'h11, "fill_rd03");
      step();
      drive(0, 1'b0, 7'd0, 8'h00, 7'd1, 7'd2, 1'b0);
      expect_rd(0, 8'h11, 8'h11, "fill_rd12");
      step();
      drive(0, 1'b1, 7'd2, 8'h77, 7'd0, 7'd2, 1'b1);
      expect_rd(0, 8'h00, 8'h00, "clr_gate");
      step();
      chk8("clr_ready", {7'b0, bus.ready}, 8'h00);
      drive(0, 1'b0, 7'd0, 8'h00, 7'd0, 7'd2, 1'b0);
      wait_ready(0, 128, "clr_sweep_edges");
      drive(0, 1'b0, 7'd0, 8'h00, 7'd0, 7'd1, 1'b0);
      expect_rd(0, 8'h00, 8'h00, "clr_rd01");
      step();
      drive(0, 1'b0, 7'd0, 8'h00, 7'd2, 7'd3, 1'b0);
      expect_rd(0, 8'h00, 8'h00, "clr_rd23");
      step();

      // clr during INIT restarts the sweep
      drive(0, 1'b0, 7'd0, 8'h00, 7'd0, 7'd0, 1'b1);
      step();
      drive(0, 1'b0, 7'd0, 8'h00, 7'd0, 7'd0, 1'b0);
      repeat (30) step();
      drive(0, 1'b0, 7'd0, 8'h00, 7'd0, 7'd0, 1'b1);
      step();
      drive(0, 1'b0, 7'd0, 8'h00, 7'd0, 7'd0, 1'b0);
      wait_ready(0, 128, "clr_init_edges");

      // Asynchronous reset from RUN, then reset mid-sweep
      drive(0, 1'b1, 7'd4, 8'h55, 7'd4, 7'd5, 1'b0);
      expect_rd(0, 8'h55, 8'h00, "pre_rst_fwd");
      step();
      drive(0, 1'b0, 7'd0, 8'h00, 7'd4, 7'd4, 1'b0);
      expect_rd(0, 8'h55, 8'h55, "pre_rst_mem");
      step();
      rst = 1'b1;
      #1;
      chk8("async_rst_ready", {7'b0, bus.ready}, 8'h00);
      chk8("async_rst_rd_a", bus.rd_data_a, 8'h00);
      repeat (2) step();
      rst = 1'b0;
      repeat (40) step();
      rst = 1'b1;
      step();
      chk8("mid_rst_ready", {7'b0, bus.ready}, 8'h00);
      rst = 1'b0;
      wait_ready(0, 128, "mid_rst_edges");
      drive(0, 1'b0, 7'd0, 8'h00, 7'd4, 7'd127, 1'b0);
      expect_rd(0, 8'h00, 8'h00, "post_rst_rd");
      step();

      chk_int("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
